// File: rtl/netlist_vec_pkg.sv
// Shared types and the Galois step used by both the pattern LFSR and the
// signature MISR of the netlist vector driver.
package netlist_vec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'hB400;
  localparam int          GSTEP_MAX_W  = 32;

  // Right-shifting Galois step; w selects the live register width (<= GSTEP_MAX_W).
  function automatic logic [GSTEP_MAX_W-1:0] galois_step(
    input logic [GSTEP_MAX_W-1:0] r,
    input logic [GSTEP_MAX_W-1:0] poly,
    input int unsigned            w
  );
    logic [GSTEP_MAX_W-1:0] mask;
    mask = ~({GSTEP_MAX_W{1'b1}} << w);
    return ((r >> 1) ^ (r[0] ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/netlist_vec_driver_galois_reg.sv
// Width-generic Galois shift register with parallel load and an XOR-in port,
// so one body serves both as pattern generator and as signature compactor.
module galois_reg
  import netlist_vec_pkg::*;
#(
  parameter int           W       = 16,
  parameter logic [W-1:0] POLY    = W'(DEFAULT_POLY),
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step_en,
  input  logic [W-1:0] xor_in,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;
  logic [W-1:0] step_next;

  assign step_next = W'(galois_step(GSTEP_MAX_W'(q_reg), GSTEP_MAX_W'(POLY), W)) ^ xor_in;

  // Load wins over step so a new run always starts from a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= RST_VAL;
    end else if (load) begin
      q_reg <= load_val;
    end else if (step_en) begin
      q_reg <= step_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/netlist_vec_driver.sv
// LFSR stimulus / MISR response driver for small combinational netlists:
// apply a vector, wait a settle window, compact the response, compare to golden.
module netlist_vec_driver
  import netlist_vec_pkg::*;
#(
  parameter int                IN_W   = 14,
  parameter int                OUT_W  = 8,
  parameter int                LFSR_W = 16,
  parameter int                MISR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(DEFAULT_POLY),
  parameter int                SETTLE = 2,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic [CNT_W-1:0]  num_vec_i,
  input  logic [MISR_W-1:0] golden_i,
  output logic [IN_W-1:0]   dut_in_o,
  input  logic [OUT_W-1:0]  dut_out_i,
  output logic              busy,
  output logic              done,
  output logic              pass_o,
  output logic [MISR_W-1:0] signature_o,
  output logic [CNT_W-1:0]  vec_cnt_o
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t state_reg, state_next;

  logic [IN_W-1:0]   dut_in_reg;
  logic [CNT_W-1:0]  vec_cnt_reg;
  logic [CNT_W-1:0]  num_reg;
  logic [SC_W-1:0]   settle_reg;
  logic              pass_reg;

  logic              load_en;
  logic              apply_en;
  logic              settle_inc;
  logic              cap_en;
  logic              done_int;
  logic              pass_upd;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_seed;
  logic [MISR_W-1:0] misr_q;
  logic [MISR_W-1:0] misr_xin;
  logic              lfsr_unused;

  genvar gi;

  // Zero-extend the DUT response onto the MISR width.
  generate
    for (gi = 0; gi < MISR_W; gi++) begin : g_xin
      if (gi < OUT_W) begin : g_bit
        assign misr_xin[gi] = dut_out_i[gi];
      end else begin : g_zero
        assign misr_xin[gi] = 1'b0;
      end
    end
  endgenerate

  // An all-zero seed would lock the LFSR at zero forever.
  assign lfsr_seed   = (seed_i == '0) ? LFSR_W'(1) : seed_i;
  assign lfsr_unused = ^lfsr_q;

  galois_reg #(
    .W       (LFSR_W),
    .POLY    (POLY),
    .RST_VAL (LFSR_W'(1))
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_en),
    .load_val (lfsr_seed),
    .step_en  (cap_en),
    .xor_in   ('0),
    .q        (lfsr_q)
  );

  galois_reg #(
    .W       (MISR_W),
    .POLY    (MISR_W'(POLY)),
    .RST_VAL ('0)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_en),
    .load_val ('0),
    .step_en  (cap_en),
    .xor_in   (misr_xin),
    .q        (misr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    apply_en   = 1'b0;
    settle_inc = 1'b0;
    cap_en     = 1'b0;
    done_int   = 1'b0;
    pass_upd   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_en    = 1'b1;
        state_next = (num_vec_i == '0) ? ST_DONE : ST_APPLY;
      end
      ST_APPLY: begin
        apply_en   = 1'b1;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_inc = 1'b1;
        if (settle_reg == SC_W'(SETTLE - 1)) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cap_en     = 1'b1;
        state_next = ((vec_cnt_reg + CNT_W'(1)) == num_reg) ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        done_int   = 1'b1;
        pass_upd   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort freezes every register and suppresses the done pulse.
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      load_en    = 1'b0;
      apply_en   = 1'b0;
      settle_inc = 1'b0;
      cap_en     = 1'b0;
      done_int   = 1'b0;
      pass_upd   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in_reg  <= '0;
      vec_cnt_reg <= '0;
      num_reg     <= '0;
      settle_reg  <= '0;
      pass_reg    <= 1'b0;
    end else begin
      if (load_en) begin
        vec_cnt_reg <= '0;
        num_reg     <= num_vec_i;
        pass_reg    <= 1'b0;
      end
      if (apply_en) begin
        dut_in_reg <= lfsr_q[IN_W-1:0];
        settle_reg <= '0;
      end
      if (settle_inc) begin
        settle_reg <= settle_reg + SC_W'(1);
      end
      if (cap_en) begin
        vec_cnt_reg <= vec_cnt_reg + CNT_W'(1);
      end
      if (pass_upd) begin
        pass_reg <= (misr_q == golden_i);
      end
    end
  end

  assign dut_in_o    = dut_in_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_int;
  assign pass_o      = pass_reg;
  assign signature_o = misr_q;
  assign vec_cnt_o   = vec_cnt_reg;

endmodule

// File: tb/tb_netlist_vec_driver.sv
// Randomized run-level bench: expected outputs per cycle are derived from the
// run's cycle arithmetic and a software LFSR/MISR, not from the RTL structure.
module tb_netlist_vec_driver;

  localparam int P = 4;  // cycles per vector with SETTLE=2

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [15:0] seed_i, num_vec_i, golden_i;
  logic [13:0] dut_in_o;
  logic [7:0]  dut_out_i;
  logic        busy, done, pass_o;
  logic [15:0] signature_o, vec_cnt_o;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int done_c;

  logic [15:0] vec_m [0:127];
  logic [15:0] sig_m [0:128];

  always #5 clk = ~clk;

  netlist_vec_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .seed_i      (seed_i),
    .num_vec_i   (num_vec_i),
    .golden_i    (golden_i),
    .dut_in_o    (dut_in_o),
    .dut_out_i   (dut_out_i),
    .busy        (busy),
    .done        (done),
    .pass_o      (pass_o),
    .signature_o (signature_o),
    .vec_cnt_o   (vec_cnt_o)
  );

  // Stand-in combinational netlist driven by the stimulus bus.
  function automatic logic [7:0] netlist(input logic [13:0] x, input int m);
    logic [15:0] t;
    case (m)
      0:       return 8'hA5;
      1:       return x[7:0] ^ x[13:6];
      default: begin
        t = {2'b00, x} * 16'd5;
        return t[7:0] ^ {x[13:10], x[3:0]};
      end
    endcase
  endfunction

  always_comb dut_out_i = netlist(dut_in_o, mode);

  function automatic logic [15:0] gstep(input logic [15:0] r);
    if (r[0]) return (r >> 1) ^ 16'hB400;
    return r >> 1;
  endfunction

  function automatic logic [15:0] model_sig(input logic [15:0] seed, input int n);
    logic [15:0] v, s;
    v = (seed == 16'h0) ? 16'h0001 : seed;
    s = 16'h0;
    for (int j = 0; j < n; j++) begin
      s = gstep(s) ^ {8'h00, netlist(v[13:0], mode)};
      v = gstep(v);
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input logic [15:0] seed, input int n, input logic [15:0] golden,
                     input int abort_at);
    int L, lim, ce, capn, ai;
    bit aborted;
    logic [15:0] v;
    v = (seed == 16'h0) ? 16'h0001 : seed;
    sig_m[0] = 16'h0;
    for (int j = 0; j < n; j++) begin
      vec_m[j]   = v;
      sig_m[j+1] = gstep(sig_m[j]) ^ {8'h00, netlist(v[13:0], mode)};
      v          = gstep(v);
    end
    L      = 2 + n * P;
    lim    = (abort_at > 0) ? abort_at + 3 : L + 2;
    done_c = -1;
    @(negedge clk);
    seed_i    = seed;
    num_vec_i = 16'(n);
    golden_i  = golden;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      aborted = (abort_at > 0) && (c > abort_at);
      ce      = aborted ? abort_at : c;
      if (done) done_c = c;
      chk("busy", 32'(busy), 32'(!aborted && c <= L));
      chk("done", 32'(done), 32'(!aborted && c == L));
      if (ce >= 2) begin
        capn = (ce - 2) / P;
        if (capn > n) capn = n;
        chk("vec_cnt", 32'(vec_cnt_o), 32'(capn));
        chk("signature", 32'(signature_o), 32'(sig_m[capn]));
        chk("pass", 32'(pass_o), 32'((!aborted && c > L) ? (sig_m[n] == golden) : 1'b0));
      end
      if (ce >= 3 && n > 0) begin
        ai = (ce - 3) / P;
        if (ai > n - 1) ai = n - 1;
        chk("dut_in", 32'(dut_in_o), 32'(vec_m[ai][13:0]));
      end
      abort = (c == abort_at);
      @(negedge clk);
    end
    abort = 1'b0;
    $display("run seed=0x%04h n=%0d mode=%0d abort_at=%0d sig=0x%04h cnt=%0d pass=%0b done_c=%0d",
             seed, n, mode, abort_at, signature_o, vec_cnt_o, pass_o, done_c);
  endtask

  initial begin
    int n, L, ab;
    logic [15:0] sd, gd;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    seed_i = 16'h0; num_vec_i = 16'h0; golden_i = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sig", 32'(signature_o), 0);
    chk("rst_dut_in", 32'(dut_in_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed results.
    mode = 0;
    run(16'h0001, 0, 16'h0000, 0);
    chk("lit_n0_done_c", 32'(done_c), 2);
    chk("lit_n0_sig", 32'(signature_o), 32'h0000);
    chk("lit_n0_pass", 32'(pass_o), 1);
    run(16'h0001, 1, 16'h00A5, 0);
    chk("lit_n1_done_c", 32'(done_c), 6);
    chk("lit_n1_dut_in", 32'(dut_in_o), 32'h0001);
    chk("lit_n1_sig", 32'(signature_o), 32'h00A5);
    chk("lit_n1_cnt", 32'(vec_cnt_o), 1);
    run(16'h0001, 2, 16'hB4F7, 0);
    chk("lit_n2_dut_in", 32'(dut_in_o), 32'h3400);
    chk("lit_n2_sig", 32'(signature_o), 32'hB4F7);
    chk("lit_n2_pass", 32'(pass_o), 1);
    run(16'h0001, 2, 16'hB4F6, 0);
    chk("lit_n2_fail_pass", 32'(pass_o), 0);
    run(16'h0000, 2, 16'hB4F7, 0);
    chk("lit_seed0_dut_in", 32'(dut_in_o), 32'h3400);
    chk("lit_seed0_sig", 32'(signature_o), 32'hB4F7);
    chk("lit_seed0_pass", 32'(pass_o), 1);

    // Asynchronous reset in the middle of a settle window.
    mode = 1;
    @(negedge clk);
    seed_i = 16'h1234; num_vec_i = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_pass", 32'(pass_o), 0);
    chk("arst_sig", 32'(signature_o), 0);
    chk("arst_cnt", 32'(vec_cnt_o), 0);
    chk("arst_dut_in", 32'(dut_in_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);

    // Abort a long run, then restart cleanly.
    mode = 2;
    run(16'($urandom), 100, 16'h0000, 23);
    chk("lit_abort_busy", 32'(busy), 0);
    chk("lit_abort_cnt", 32'(vec_cnt_o), 5);
    sd = 16'($urandom);
    run(sd, 3, model_sig(sd, 3), 0);
    chk("lit_restart_cnt", 32'(vec_cnt_o), 3);
    chk("lit_restart_pass", 32'(pass_o), 1);

    // Randomized runs, some matching golden, some aborted.
    for (int k = 0; k < 24; k++) begin
      mode = int'($urandom_range(0, 2));
      n    = int'($urandom_range(1, 12));
      sd   = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      gd   = $urandom_range(0, 1) ? model_sig(sd, n) : 16'($urandom);
      L    = 2 + n * P;
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, L)) : 0;
      run(sd, n, gd, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/netlist_vec_driver.md
Name: netlist_vec_driver

Overview:
- Stimulus/response end for the contest's combinational gate-level netlists (14-in/8-out class).
- Generates pseudo-random input vectors from an LFSR and drives them onto the DUT input bus.
- Waits a settle window, then compacts each DUT output vector into a MISR signature.
- Flags pass/fail against a golden signature; used to check equivalence of original and optimized netlists in simulation and on FPGA.

Parameters:
- IN_W, 14, DUT input width; must be ≤ LFSR_W.
- OUT_W, 8, DUT output width; must be ≤ MISR_W.
- LFSR_W, 16, pattern LFSR width.
- MISR_W, 16, signature register width.
- POLY, 16'hB400, Galois feedback mask shared by LFSR and MISR.
- SETTLE, 2, wait cycles between apply and capture (≥1).
- CNT_W, 16, vector counter width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- abort  in  1  cancel run; return to IDLE without done.
- seed_i  in  LFSR_W  LFSR seed; sampled in LOAD.
- num_vec_i  in  CNT_W  vectors to apply; sampled in LOAD.
- golden_i  in  MISR_W  expected signature; compared in DONE.
- dut_in_o  out  IN_W  registered stimulus to DUT.
- dut_out_i  in  OUT_W  DUT response.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- pass_o  out  1  signature == golden_i; held until next LOAD.
- signature_o  out  MISR_W  current MISR contents.
- vec_cnt_o  out  CNT_W  vectors captured so far.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dut_in_o=0, busy=0, done=0, pass_o=0, signature_o=0, vec_cnt_o=0, LFSR=1, settle counter=0.
- Galois step, both registers: nxt = (r >> 1) ^ (r[0] ? POLY : 0).
- MISR update: sig <= step(sig) ^ zero-extended dut_out_i.
- FSM states: IDLE, LOAD, APPLY, SETTLE, CAPTURE, DONE.
- IDLE: start=1 → LOAD. Otherwise hold.
- LOAD (1 cycle):
  - LFSR <= (seed_i==0) ? 1 : seed_i (lock-up guard).
  - sig <= 0; vec_cnt_o <= 0; pass_o <= 0; latch num_vec_i.
  - num_vec_i==0 → DONE; else → APPLY.
- APPLY (1 cycle): dut_in_o <= LFSR[IN_W-1:0]; settle counter <= 0; → SETTLE.
- SETTLE: counter increments each cycle; after SETTLE cycles → CAPTURE.
- CAPTURE (1 cycle):
  - MISR update; LFSR <= step(LFSR); vec_cnt_o <= vec_cnt_o+1.
  - If vec_cnt_o+1 == latched count → DONE; else → APPLY.
- Per-vector cost: SETTLE+2 cycles.
- Latency: start cycle to done pulse = 2 + N*(SETTLE+2) cycles.
- DONE (1 cycle): done=1; pass_o <= (sig == golden_i); → IDLE.
- dut_in_o holds its last vector after the run.
- start outside IDLE: ignored; no queuing.
- abort in any non-IDLE state: → IDLE next cycle.
  - done is not pulsed; pass_o is left at 0.
  - Signature and count are frozen at their current values.
  - abort takes priority over every transition, including DONE.
- Wrap-around: vec_cnt_o compares at full CNT_W; num_vec_i = 2^CNT_W−1 is the maximum; no modular wrap.
- The LFSR may repeat if N exceeds its period; this is not flagged.

Decomposition:
- Package netlist_vec_pkg:
  - state enum (IDLE..DONE).
  - default POLY constant.
  - galois_step function with a width argument.
- Sub-module galois_reg: a width-generic register with load/step/xor-in ports, instanced twice.
  - LFSR instance: xor-in tied to 0.
  - MISR instance.
- FSM and counters live in the top.

Test Plan:
- Reset: assert rst_n=0 mid-SETTLE → all outputs return to reset values asynchronously; after release, state=IDLE and busy=0.
- num_vec_i=0, start → done 2 cycles after start, signature_o=0x0000; with golden_i=0 → pass_o=1.
- seed_i=0x0001, num_vec_i=1, dut_out_i tied 0xA5, SETTLE=2 → dut_in_o=0x0001, signature_o=0x00A5, vec_cnt_o=1, done 6 cycles after start.
- Same settings with num_vec_i=2:
  - Second vector: dut_in_o=0x3400 (LFSR 0xB400 masked to 14 bits).
  - signature_o=0xB4F7; with golden_i=0xB4F7 → pass_o=1; with golden_i=0xB4F6 → pass_o=0.
- seed_i=0 → LFSR loads 1; results identical to the seed=1 case.
- abort during run with num_vec_i=100 → IDLE next cycle, no done pulse, busy=0; a new start restarts cleanly with vec_cnt_o reset to 0.
